// File: rtl/nexys_starship_score_timer_pkg.sv
// rtl/nexys_starship_score_timer_pkg.sv - shared state encodings and BCD constants
package nexys_starship_score_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [15:0] BCD_MAX  = 16'h9999;
   localparam logic [15:0] BCD_ZERO = 16'h0000;

endpackage

// File: rtl/nexys_starship_score_timer_bcd_inc4.sv
// rtl/nexys_starship_score_timer_bcd_inc4.sv - combinational 4-digit packed BCD +1, saturating at 9999
module bcd_inc4
   import nexys_starship_score_timer_pkg::*;
(
   input  logic [15:0] value,
   output logic [15:0] result,
   output logic        saturated
);

   logic       carry;
   logic [3:0] digit;

   always_comb begin
      result    = value;
      carry     = 1'b1;
      digit     = 4'd0;
      saturated = (value == BCD_MAX);
      for (int i = 0; i < 4; i++) begin
         digit = value[4*i +: 4];
         if (carry) begin
            if (digit == 4'd9) begin
               result[4*i +: 4] = 4'd0;
            end else begin
               result[4*i +: 4] = digit + 4'd1;
               carry            = 1'b0;
            end
         end
      end
      // 9999 must hold rather than roll over to 0000
      if (saturated) result = value;
   end

endmodule

// File: rtl/nexys_starship_score_timer.sv
// rtl/nexys_starship_score_timer.sv - survival-time score counter with frozen final score and best-score tracking
module nexys_starship_score_timer
   import nexys_starship_score_timer_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int CNT_W    = 27
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        play_flag,
   input  logic        gameover_ctrl,
   input  logic        restart,
   output logic [15:0] score_bcd,
   output logic [15:0] best_bcd,
   output logic        new_best,
   output logic        sec_tick,
   output logic        q_ST_Idle,
   output logic        q_ST_Run,
   output logic        q_ST_Done
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] prescaler;
   logic             terminal;
   logic             start_run, tick_now, end_round;
   logic [15:0]      score_inc;
   logic             score_sat;

   assign terminal = (prescaler == TERM);

   bcd_inc4 u_inc (
      .value     (score_bcd),
      .result    (score_inc),
      .saturated (score_sat)
   );

   always_ff @(posedge Clk) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // gameover has priority over both a terminal count and a play abort
   always_comb begin
      state_next = state;
      start_run  = 1'b0;
      tick_now   = 1'b0;
      end_round  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (play_flag && !gameover_ctrl) begin
               state_next = ST_RUN;
               start_run  = 1'b1;
            end
         end
         ST_RUN: begin
            if (gameover_ctrl) begin
               state_next = ST_DONE;
               end_round  = 1'b1;
            end else if (!play_flag) begin
               state_next = ST_IDLE;
            end else if (terminal) begin
               tick_now = 1'b1;
            end
         end
         ST_DONE: begin
            if (restart) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         prescaler <= '0;
         score_bcd <= BCD_ZERO;
         best_bcd  <= BCD_ZERO;
         new_best  <= 1'b0;
         sec_tick  <= 1'b0;
      end else begin
         sec_tick <= tick_now;
         if (state == ST_RUN && state_next == ST_RUN && !terminal)
            prescaler <= prescaler + CNT_W'(1);
         else
            prescaler <= '0;
         if (start_run) begin
            score_bcd <= BCD_ZERO;
            new_best  <= 1'b0;
         end
         if (tick_now && !score_sat)
            score_bcd <= score_inc;
         // packed BCD orders the same as binary, so a plain compare works
         if (end_round) begin
            if (score_bcd > best_bcd) begin
               best_bcd <= score_bcd;
               new_best <= 1'b1;
            end else begin
               new_best <= 1'b0;
            end
         end
         if (state == ST_DONE && restart)
            new_best <= 1'b0;
      end
   end

   assign q_ST_Idle = (state == ST_IDLE);
   assign q_ST_Run  = (state == ST_RUN);
   assign q_ST_Done = (state == ST_DONE);

endmodule

// File: tb/tb_nexys_starship_score_timer.sv
// tb/tb_nexys_starship_score_timer.sv - directed table-driven bench for the score timer at TICK_DIV=4
module tb_nexys_starship_score_timer;

   localparam logic [2:0] S_IDLE = 3'b001;
   localparam logic [2:0] S_RUN  = 3'b010;
   localparam logic [2:0] S_DONE = 3'b100;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        play_flag = 1'b0;
   logic        gameover_ctrl = 1'b0;
   logic        restart = 1'b0;
   logic [15:0] score_bcd, best_bcd;
   logic        new_best, sec_tick, q_ST_Idle, q_ST_Run, q_ST_Done;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic        play, go, rst;
      logic [2:0]  st;
      logic [15:0] score, best;
      logic        nb, tick;
   } vec_t;

   vec_t vecs[$];

   nexys_starship_score_timer #(.TICK_DIV(4), .CNT_W(3)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .play_flag     (play_flag),
      .gameover_ctrl (gameover_ctrl),
      .restart       (restart),
      .score_bcd     (score_bcd),
      .best_bcd      (best_bcd),
      .new_best      (new_best),
      .sec_tick      (sec_tick),
      .q_ST_Idle     (q_ST_Idle),
      .q_ST_Run      (q_ST_Run),
      .q_ST_Done     (q_ST_Done)
   );

   always #5 Clk = ~Clk;

   function automatic logic [15:0] to_bcd(input int n);
      return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic logic [36:0] pack(input logic [2:0] st, input logic [15:0] sc,
                                        input logic [15:0] bs, input logic nb, input logic tk);
      return {st, sc, bs, nb, tk};
   endfunction

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got st/score/best/nb/tick=%h required %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] st, input logic [15:0] sc,
                            input logic [15:0] bs, input logic nb, input logic tk);
      check(name, pack({q_ST_Done, q_ST_Run, q_ST_Idle}, score_bcd, best_bcd, new_best, sec_tick),
            pack(st, sc, bs, nb, tk));
   endtask

   task automatic step(input logic p, input logic g, input logic r);
      play_flag     = p;
      gameover_ctrl = g;
      restart       = r;
      @(posedge Clk);
      #1;
   endtask

   task automatic add(input logic p, input logic g, input logic r, input logic [2:0] st,
                      input logic [15:0] sc, input logic [15:0] bs, input logic nb, input logic tk);
      vec_t v;
      v.play = p; v.go = g; v.rst = r; v.st = st;
      v.score = sc; v.best = bs; v.nb = nb; v.tick = tk;
      vecs.push_back(v);
   endtask

   // n seconds of play starting right after a tick (or Run entry) at score 'from' (< 10)
   task automatic add_run(input int n, input int from, input logic [15:0] bs);
      for (int k = 1; k <= n; k++) begin
         for (int j = 0; j < 3; j++) add(1, 0, 0, S_RUN, 16'(from + k - 1), bs, 0, 0);
         add(1, 0, 0, S_RUN, 16'(from + k), bs, 0, 1);
      end
   endtask

   initial begin
      logic [3:0] pat;

      // round 1: idle, play+gameover ignored, run to 5, game over sets best
      add(0, 0, 0, S_IDLE, 16'h0, 16'h0, 0, 0);
      add(1, 1, 0, S_IDLE, 16'h0, 16'h0, 0, 0);
      add(1, 0, 0, S_RUN,  16'h0, 16'h0, 0, 0);
      add_run(5, 0, 16'h0);
      add(1, 1, 0, S_DONE, 16'h5, 16'h5, 1, 0);
      add(1, 1, 0, S_DONE, 16'h5, 16'h5, 1, 0);
      add(0, 0, 1, S_IDLE, 16'h5, 16'h5, 0, 0);
      add(0, 0, 1, S_IDLE, 16'h5, 16'h5, 0, 0);
      // round 2: restart ignored in Run, ends at 3, best stays 5
      add(1, 0, 0, S_RUN,  16'h0, 16'h5, 0, 0);
      add(1, 0, 1, S_RUN,  16'h0, 16'h5, 0, 0);
      add(1, 0, 0, S_RUN,  16'h0, 16'h5, 0, 0);
      add(1, 0, 0, S_RUN,  16'h0, 16'h5, 0, 0);
      add(1, 0, 0, S_RUN,  16'h1, 16'h5, 0, 1);
      add_run(2, 1, 16'h5);
      add(1, 1, 0, S_DONE, 16'h3, 16'h5, 0, 0);
      add(0, 0, 1, S_IDLE, 16'h3, 16'h5, 0, 0);
      // round 3: gameover on the terminal prescaler count at score 2
      add(1, 0, 0, S_RUN,  16'h0, 16'h5, 0, 0);
      add_run(2, 0, 16'h5);
      for (int j = 0; j < 3; j++) add(1, 0, 0, S_RUN, 16'h2, 16'h5, 0, 0);
      add(1, 1, 0, S_DONE, 16'h2, 16'h5, 0, 0);
      add(0, 0, 1, S_IDLE, 16'h2, 16'h5, 0, 0);
      // round 4: play aborted, best untouched; play+gameover in Idle stays Idle
      add(1, 0, 0, S_RUN,  16'h0, 16'h5, 0, 0);
      add_run(1, 0, 16'h5);
      add(0, 0, 0, S_IDLE, 16'h1, 16'h5, 0, 0);
      add(1, 1, 0, S_IDLE, 16'h1, 16'h5, 0, 0);

      Reset = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      check_all("reset", S_IDLE, 16'h0, 16'h0, 0, 0);
      Reset = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].play, vecs[i].go, vecs[i].rst);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].score, vecs[i].best,
                   vecs[i].nb, vecs[i].tick);
      end

      // reset mid-Run at 0007 with best 0005 clears everything
      step(1, 0, 0);
      for (int k = 0; k < 28; k++) step(1, 0, 0);
      check_all("run_to_7", S_RUN, 16'h7, 16'h5, 0, 1);
      Reset = 1'b1;
      step(1, 0, 0);
      check_all("reset_mid_run", S_IDLE, 16'h0, 16'h0, 0, 0);
      Reset = 1'b0;

      // full count through every carry up to saturation
      step(1, 0, 0);
      for (int n = 1; n <= 10001; n++) begin
         for (int j = 0; j < 4; j++) begin
            step(1, 0, 0);
            pat[j] = sec_tick;
         end
         check($sformatf("tick_n%0d", n), {33'd0, pat}, {33'd0, 4'b1000});
         check($sformatf("score_n%0d", n), {21'd0, score_bcd}, {21'd0, to_bcd(n > 9999 ? 9999 : n)});
      end
      step(1, 1, 0);
      check_all("sat_gameover", S_DONE, 16'h9999, 16'h9999, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
